// File: rtl/sd_wb_regbank_if.sv
// Wishbone classic bus bundle for the SD host register bank.
// Defining SD_WB_ERR_EN adds the wb_err_o error-termination signal.
interface sd_wb_regbank_if #(
  parameter int ADR_W = 8
);
  logic [31:0]      wb_dat_i;
  logic [31:0]      wb_dat_o;
  logic [ADR_W-1:0] wb_adr_i;
  logic [3:0]       wb_sel_i;
  logic             wb_we_i;
  logic             wb_cyc_i;
  logic             wb_stb_i;
  logic             wb_ack_o;
`ifdef SD_WB_ERR_EN
  logic             wb_err_o;

  modport master (
    output wb_dat_i, wb_adr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );
  modport slave (
    input  wb_dat_i, wb_adr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
`else
  modport master (
    output wb_dat_i, wb_adr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );
  modport slave (
    input  wb_dat_i, wb_adr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );
`endif
endinterface

// File: rtl/sd_wb_regbank.sv
// SD host Wishbone register bank: config/command registers, sticky W1C interrupts,
// busy-interlocked command start. Macro SD_WB_ERR_EN enables wb_err_o termination.
module sd_wb_regbank #(
  parameter int ADR_W            = 8,
  parameter int WAIT_STATES      = 0,
  parameter int CMD_W            = 14,
  parameter int CMD_TIMEOUT_W    = 24,
  parameter int DATA_TIMEOUT_W   = 24,
  parameter int BLKSIZE_W        = 12,
  parameter int BLKCNT_W         = 16,
  parameter int N_CMD_INT        = 5,
  parameter int N_DATA_INT       = 3,
  parameter int RESET_BLOCK_SIZE = 511,
  parameter int RESET_CLK_DIV    = 0,
  parameter int SUPPLY_MV        = 3300
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  sd_wb_regbank_if.slave            wb,
  input  logic                      cmd_busy_i,
  output logic                      cmd_start_o,
  input  logic [127:0]              resp_i,
  input  logic [N_CMD_INT-1:0]      cmd_evt_i,
  input  logic [N_DATA_INT-1:0]     data_evt_i,
  output logic [31:0]               argument_o,
  output logic [CMD_W-1:0]          command_o,
  output logic                      controller_o,
  output logic                      software_reset_o,
  output logic [CMD_TIMEOUT_W-1:0]  cmd_timeout_o,
  output logic [DATA_TIMEOUT_W-1:0] data_timeout_o,
  output logic [7:0]                clock_divider_o,
  output logic [BLKSIZE_W-1:0]      block_size_o,
  output logic [BLKCNT_W-1:0]       block_count_o,
  output logic [31:0]               dma_addr_o,
  output logic                      cmd_int_o,
  output logic                      data_int_o
);
  localparam logic [ADR_W-1:0] A_ARG   = ADR_W'(8'h00);
  localparam logic [ADR_W-1:0] A_CMD   = ADR_W'(8'h04);
  localparam logic [ADR_W-1:0] A_RESP0 = ADR_W'(8'h08);
  localparam logic [ADR_W-1:0] A_RESP1 = ADR_W'(8'h0C);
  localparam logic [ADR_W-1:0] A_RESP2 = ADR_W'(8'h10);
  localparam logic [ADR_W-1:0] A_RESP3 = ADR_W'(8'h14);
  localparam logic [ADR_W-1:0] A_CTRL  = ADR_W'(8'h1C);
  localparam logic [ADR_W-1:0] A_CTO   = ADR_W'(8'h20);
  localparam logic [ADR_W-1:0] A_CLKD  = ADR_W'(8'h24);
  localparam logic [ADR_W-1:0] A_RST   = ADR_W'(8'h28);
  localparam logic [ADR_W-1:0] A_VOLT  = ADR_W'(8'h2C);
  localparam logic [ADR_W-1:0] A_CAPA  = ADR_W'(8'h30);
  localparam logic [ADR_W-1:0] A_CISR  = ADR_W'(8'h34);
  localparam logic [ADR_W-1:0] A_CISER = ADR_W'(8'h38);
  localparam logic [ADR_W-1:0] A_DISR  = ADR_W'(8'h3C);
  localparam logic [ADR_W-1:0] A_DISER = ADR_W'(8'h40);
  localparam logic [ADR_W-1:0] A_BSIZE = ADR_W'(8'h44);
  localparam logic [ADR_W-1:0] A_BCNT  = ADR_W'(8'h48);
  localparam logic [ADR_W-1:0] A_DTO   = ADR_W'(8'h4C);
  localparam logic [ADR_W-1:0] A_DMA   = ADR_W'(8'h60);

  localparam logic [2:0] LAST_WAIT = 3'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t                  state, state_nxt;
  logic [2:0]              wait_cnt;
  logic                    req, commit, wr;
  logic [ADR_W-1:0]        addr;
  logic [31:0]             lane_mask, rdata, dat_q;
  logic [N_CMD_INT-1:0]    cmd_status, cmd_enable, cmd_clr;
  logic [N_DATA_INT-1:0]   data_status, data_enable, data_clr;
  logic                    ack;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [31:0] m);
    return (old & ~m) | (d & m);
  endfunction

  assign req       = wb.wb_cyc_i & wb.wb_stb_i;
  assign addr      = wb.wb_adr_i;
  assign lane_mask = {{8{wb.wb_sel_i[3]}}, {8{wb.wb_sel_i[2]}},
                      {8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}};
  // Writes and read capture both happen on the edge that enters ACK.
  assign commit    = (state_nxt == ST_ACK) && (state != ST_ACK);
  assign wr        = commit & wb.wb_we_i;
  assign cmd_clr   = (wr && addr == A_CISR) ? N_CMD_INT'(wb.wb_dat_i & lane_mask) : '0;
  assign data_clr  = (wr && addr == A_DISR) ? N_DATA_INT'(wb.wb_dat_i & lane_mask) : '0;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + 3'd1 : 3'd0;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (req) state_nxt = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
      ST_WAIT: if (!req) state_nxt = ST_IDLE;
               else if (wait_cnt == LAST_WAIT) state_nxt = ST_ACK;
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef SD_WB_ERR_EN
  logic bad, bad_q, err;

  always_comb begin
    bad = 1'b1;
    case (addr)
      A_RESP0, A_RESP1, A_RESP2, A_RESP3, A_VOLT, A_CAPA: bad = wb.wb_we_i;
      A_ARG, A_CMD, A_CTRL, A_CTO, A_CLKD, A_RST, A_CISR, A_CISER,
      A_DISR, A_DISER, A_BSIZE, A_BCNT, A_DTO, A_DMA:     bad = 1'b0;
      default:                                            bad = 1'b1;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)    bad_q <= 1'b0;
    else if (commit) bad_q <= bad;
  end

  always_comb begin
    ack = 1'b0;
    err = 1'b0;
    if (state == ST_ACK) begin
      ack = !bad_q;
      err = bad_q;
    end
  end
  assign wb.wb_err_o = err;
`else
  always_comb begin
    ack = 1'b0;
    if (state == ST_ACK) ack = 1'b1;
  end
`endif
  assign wb.wb_ack_o = ack;

  always_comb begin
    rdata = '0;
    case (addr)
      A_ARG:   rdata = argument_o;
      A_CMD:   rdata = 32'(command_o);
      A_RESP0: rdata = resp_i[31:0];
      A_RESP1: rdata = resp_i[63:32];
      A_RESP2: rdata = resp_i[95:64];
      A_RESP3: rdata = resp_i[127:96];
      A_CTRL:  rdata = 32'(controller_o);
      A_CTO:   rdata = 32'(cmd_timeout_o);
      A_CLKD:  rdata = 32'(clock_divider_o);
      A_RST:   rdata = 32'(software_reset_o);
      A_VOLT:  rdata = 32'(SUPPLY_MV);
      A_CISR:  rdata = 32'(cmd_status);
      A_CISER: rdata = 32'(cmd_enable);
      A_DISR:  rdata = 32'(data_status);
      A_DISER: rdata = 32'(data_enable);
      A_BSIZE: rdata = 32'(block_size_o);
      A_BCNT:  rdata = 32'(block_count_o);
      A_DTO:   rdata = 32'(data_timeout_o);
      A_DMA:   rdata = dma_addr_o;
      default: rdata = '0;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      dat_q            <= '0;
      cmd_start_o      <= 1'b0;
      argument_o       <= '0;
      command_o        <= '0;
      controller_o     <= 1'b0;
      software_reset_o <= 1'b0;
      cmd_timeout_o    <= '0;
      data_timeout_o   <= '0;
      clock_divider_o  <= 8'(RESET_CLK_DIV);
      block_size_o     <= BLKSIZE_W'(RESET_BLOCK_SIZE);
      block_count_o    <= '0;
      dma_addr_o       <= '0;
      cmd_status       <= '0;
      cmd_enable       <= '0;
      data_status      <= '0;
      data_enable      <= '0;
    end else begin
      cmd_start_o <= 1'b0;
      if (commit) dat_q <= wb.wb_we_i ? 32'd0 : rdata;
      // A busy command master makes an argument write a no-op, so no new command launches.
      if (wr && addr == A_ARG && !cmd_busy_i) begin
        argument_o  <= merge(argument_o, wb.wb_dat_i, lane_mask);
        cmd_start_o <= 1'b1;
      end
      if (wr && addr == A_CMD)
        command_o <= CMD_W'(merge(32'(command_o), wb.wb_dat_i, lane_mask));
      if (wr && addr == A_CTRL)
        controller_o <= 1'(merge(32'(controller_o), wb.wb_dat_i, lane_mask));
      if (wr && addr == A_RST)
        software_reset_o <= 1'(merge(32'(software_reset_o), wb.wb_dat_i, lane_mask));
      if (wr && addr == A_CTO)
        cmd_timeout_o <= CMD_TIMEOUT_W'(merge(32'(cmd_timeout_o), wb.wb_dat_i, lane_mask));
      if (wr && addr == A_DTO)
        data_timeout_o <= DATA_TIMEOUT_W'(merge(32'(data_timeout_o), wb.wb_dat_i, lane_mask));
      if (wr && addr == A_CLKD)
        clock_divider_o <= 8'(merge(32'(clock_divider_o), wb.wb_dat_i, lane_mask));
      if (wr && addr == A_BSIZE)
        block_size_o <= BLKSIZE_W'(merge(32'(block_size_o), wb.wb_dat_i, lane_mask));
      if (wr && addr == A_BCNT)
        block_count_o <= BLKCNT_W'(merge(32'(block_count_o), wb.wb_dat_i, lane_mask));
      if (wr && addr == A_DMA)
        dma_addr_o <= merge(dma_addr_o, wb.wb_dat_i, lane_mask);
      if (wr && addr == A_CISER)
        cmd_enable <= N_CMD_INT'(merge(32'(cmd_enable), wb.wb_dat_i, lane_mask));
      if (wr && addr == A_DISER)
        data_enable <= N_DATA_INT'(merge(32'(data_enable), wb.wb_dat_i, lane_mask));
      // OR-ing events in after the clear makes a same-edge set win.
      cmd_status  <= (cmd_status & ~cmd_clr) | cmd_evt_i;
      data_status <= (data_status & ~data_clr) | data_evt_i;
    end
  end

  assign wb.wb_dat_o = dat_q;
  assign cmd_int_o   = |(cmd_status & cmd_enable);
  assign data_int_o  = |(data_status & data_enable);
endmodule

// File: tb/tb_sd_wb_regbank.sv
// Self-checking bench: zero-wait-state bank driven by directed and random accesses
// against a register-map model, plus a three-wait-state bank for latency and abort.
module tb_sd_wb_regbank;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sd_wb_regbank_if #(.ADR_W(8)) bus_a ();
  sd_wb_regbank_if #(.ADR_W(8)) bus_b ();

  logic         cmd_busy;
  logic [127:0] resp;
  logic [4:0]   cmd_evt;
  logic [2:0]   data_evt;

  logic        start_a, ctrl_a, swrst_a, cint_a, dint_a;
  logic [31:0] arg_a, dma_a;
  logic [13:0] command_a;
  logic [23:0] cto_a, dto_a;
  logic [7:0]  clkdiv_a;
  logic [11:0] bsize_a;
  logic [15:0] bcnt_a;

  logic        start_b, ctrl_b, swrst_b, cint_b, dint_b;
  logic [31:0] arg_b, dma_b;
  logic [13:0] command_b;
  logic [23:0] cto_b, dto_b;
  logic [7:0]  clkdiv_b;
  logic [11:0] bsize_b;
  logic [15:0] bcnt_b;

  sd_wb_regbank dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus_a), .cmd_busy_i(cmd_busy),
    .cmd_start_o(start_a), .resp_i(resp), .cmd_evt_i(cmd_evt), .data_evt_i(data_evt),
    .argument_o(arg_a), .command_o(command_a), .controller_o(ctrl_a),
    .software_reset_o(swrst_a), .cmd_timeout_o(cto_a), .data_timeout_o(dto_a),
    .clock_divider_o(clkdiv_a), .block_size_o(bsize_a), .block_count_o(bcnt_a),
    .dma_addr_o(dma_a), .cmd_int_o(cint_a), .data_int_o(dint_a)
  );

  sd_wb_regbank #(.WAIT_STATES(3)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus_b), .cmd_busy_i(cmd_busy),
    .cmd_start_o(start_b), .resp_i(resp), .cmd_evt_i(cmd_evt), .data_evt_i(data_evt),
    .argument_o(arg_b), .command_o(command_b), .controller_o(ctrl_b),
    .software_reset_o(swrst_b), .cmd_timeout_o(cto_b), .data_timeout_o(dto_b),
    .clock_divider_o(clkdiv_b), .block_size_o(bsize_b), .block_count_o(bcnt_b),
    .dma_addr_o(dma_b), .cmd_int_o(cint_b), .data_int_o(dint_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: register contents by byte address, with per-register width masks.
  logic [31:0] mreg  [int];
  logic [31:0] wmask [int];

  task automatic model_reset();
    int regs [14] = '{'h00, 'h04, 'h1C, 'h20, 'h24, 'h28, 'h34, 'h38, 'h3C, 'h40,
                      'h44, 'h48, 'h4C, 'h60};
    logic [31:0] masks [14] = '{32'hFFFF_FFFF, 32'h3FFF, 32'h1, 32'hFF_FFFF, 32'hFF,
                                32'h1, 32'h1F, 32'h1F, 32'h7, 32'h7, 32'hFFF, 32'hFFFF,
                                32'hFF_FFFF, 32'hFFFF_FFFF};
    for (int i = 0; i < 14; i++) begin
      wmask[regs[i]] = masks[i];
      mreg[regs[i]]  = 32'h0;
    end
    mreg['h44] = 32'd511;
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  task automatic model_write(input int a, input logic [31:0] d, input logic [3:0] s,
                             input logic busy);
    logic [31:0] m;
    m = lanes(s);
    if (!mreg.exists(a)) return;
    if (a == 'h34 || a == 'h3C) mreg[a] = mreg[a] & ~(d & m & wmask[a]);
    else if (a != 'h00 || !busy) mreg[a] = ((mreg[a] & ~m) | (d & m)) & wmask[a];
  endtask

  function automatic logic [31:0] model_read(input int a);
    if (a >= 'h08 && a <= 'h14) return resp[(a - 'h08) * 8 +: 32];
    if (a == 'h2C) return 32'd3300;
    if (mreg.exists(a)) return mreg[a];
    return 32'h0;
  endfunction

  // Results of the latest access on bus_a.
  logic [31:0] rd;
  int          lat;
  logic        st_ack, st_after, got_err;

  task automatic access(input logic we, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [4:0] cevt);
    logic done;
    @(negedge clk);
    bus_a.wb_cyc_i = 1'b1; bus_a.wb_stb_i = 1'b1; bus_a.wb_we_i = we;
    bus_a.wb_adr_i = a;    bus_a.wb_dat_i = d;    bus_a.wb_sel_i = s;
    cmd_evt = cevt;
    done = 1'b0; got_err = 1'b0; lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1 cmd_evt = '0;
      @(negedge clk);
      lat++;
      if (bus_a.wb_ack_o) done = 1'b1;
`ifdef SD_WB_ERR_EN
      if (bus_a.wb_err_o) begin done = 1'b1; got_err = 1'b1; end
`endif
    end
    check($sformatf("ack_seen_%h", a), 32'(done), 32'd1);
    rd = bus_a.wb_dat_o;
    st_ack = start_a;
    bus_a.wb_cyc_i = 1'b0; bus_a.wb_stb_i = 1'b0; bus_a.wb_we_i = 1'b0;
    @(negedge clk);
    st_after = start_a;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int addrs [23] = '{'h00, 'h04, 'h08, 'h0C, 'h10, 'h14, 'h18, 'h1C, 'h20, 'h24, 'h28,
                       'h2C, 'h30, 'h34, 'h38, 'h3C, 'h40, 'h44, 'h48, 'h4C, 'h50, 'h60,
                       'h7C};
    logic [5:0]  pattern;
    logic        seen;
    int          k, a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        busy;

    bus_a.wb_cyc_i = 0; bus_a.wb_stb_i = 0; bus_a.wb_we_i = 0;
    bus_a.wb_adr_i = 0; bus_a.wb_dat_i = 0; bus_a.wb_sel_i = 0;
    bus_b.wb_cyc_i = 0; bus_b.wb_stb_i = 0; bus_b.wb_we_i = 0;
    bus_b.wb_adr_i = 0; bus_b.wb_dat_i = 0; bus_b.wb_sel_i = 0;
    cmd_busy = 0; cmd_evt = 0; data_evt = 0;
    resp = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

    do_reset();
    @(negedge clk);
    check("rst_bsize", 32'(bsize_a), 32'd511);
    check("rst_clkdiv", 32'(clkdiv_a), 32'd0);
    check("rst_arg", arg_a, 32'd0);
    check("rst_misc", {command_a, ctrl_a, swrst_a, start_a, cint_a, dint_a,
                       bus_a.wb_ack_o, bus_b.wb_ack_o}, 32'd0);
    check("rst_tmo", {cto_a, clkdiv_a}, 32'd0);
    check("rst_dto_bcnt", {dto_a, 8'h0} | 32'(bcnt_a), 32'd0);
    check("rst_dma", dma_a, 32'd0);
    check("rst_dat", bus_a.wb_dat_o, 32'd0);

    access(0, 8'h2C, 0, 4'hF, 0);
    check("volt", rd, 32'd3300);
    check("lat0", 32'(lat), 32'd1);
    access(0, 8'h30, 0, 4'hF, 0);
    check("capa", rd, 32'd0);

    access(1, 8'h00, 32'h0102_0304, 4'hF, 0);
    check("arg_wr", arg_a, 32'h0102_0304);
    check("start_pulse", 32'(st_ack), 32'd1);
    check("start_one", 32'(st_after), 32'd0);
    cmd_busy = 1;
    access(1, 8'h00, 32'hAABB_CCDD, 4'hF, 0);
    check("arg_busy", arg_a, 32'h0102_0304);
    check("start_busy", 32'(st_ack | st_after), 32'd0);
    cmd_busy = 0;

    access(1, 8'h4C, 32'h0000_FFFF, 4'b0001, 0);
    check("dto_lane", 32'(dto_a), 32'h0000_00FF);

    access(1, 8'h38, 32'h02, 4'hF, 0);
    @(negedge clk) cmd_evt = 5'h1A;
    @(negedge clk) cmd_evt = 5'h00;
    check("cint_set", 32'(cint_a), 32'd1);
    access(0, 8'h34, 0, 4'hF, 0);
    check("cisr_rd", rd, 32'h1A);
    access(1, 8'h34, 32'h02, 4'hF, 5'h02);
    access(0, 8'h34, 0, 4'hF, 0);
    check("cisr_set_wins", rd, 32'h1A);
    access(1, 8'h34, 32'h02, 4'hF, 0);
    access(0, 8'h34, 0, 4'hF, 0);
    check("cisr_clr", rd, 32'h18);
    check("cint_clr", 32'(cint_a), 32'd0);

    access(1, 8'h40, 32'h4, 4'hF, 0);
    @(negedge clk) data_evt = 3'h5;
    @(negedge clk) data_evt = 3'h0;
    check("dint_set", 32'(dint_a), 32'd1);
    access(1, 8'h3C, 32'hFF, 4'h0, 0);
    access(0, 8'h3C, 0, 4'hF, 0);
    check("disr_nosel", rd, 32'h5);
    access(1, 8'h3C, 32'hFF, 4'h1, 0);
    access(0, 8'h3C, 0, 4'hF, 0);
    check("disr_clr", rd, 32'h0);
    check("dint_clr", 32'(dint_a), 32'd0);

    access(1, 8'h08, 32'hDEAD_BEEF, 4'hF, 0);
`ifdef SD_WB_ERR_EN
    check("err_ro_wr", 32'(got_err), 32'd1);
`endif
    access(0, 8'h08, 0, 4'hF, 0);
    check("resp_ro", rd, 32'h1111_1111);
    access(0, 8'h7C, 0, 4'hF, 0);
    check("unmapped_rd", rd, 32'h0);
`ifdef SD_WB_ERR_EN
    check("err_unmapped", 32'(got_err), 32'd1);
`endif

    // Held strobe: acks must alternate with idle cycles.
    @(negedge clk);
    bus_a.wb_cyc_i = 1; bus_a.wb_stb_i = 1; bus_a.wb_we_i = 0; bus_a.wb_adr_i = 8'h2C;
    for (int i = 5; i >= 0; i--) begin
      @(negedge clk);
      pattern[i] = bus_a.wb_ack_o;
    end
    bus_a.wb_cyc_i = 0; bus_a.wb_stb_i = 0;
    check("held_stb", 32'(pattern), 32'b101010);
    @(negedge clk);

    // Three wait states: ack exactly four edges after the strobe is sampled.
    @(negedge clk);
    bus_b.wb_cyc_i = 1; bus_b.wb_stb_i = 1; bus_b.wb_we_i = 1;
    bus_b.wb_adr_i = 8'h1C; bus_b.wb_dat_i = 32'h1; bus_b.wb_sel_i = 4'hF;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus_b.wb_ack_o && k < 20);
    check("b_latency", 32'(k), 32'd4);
    bus_b.wb_cyc_i = 0; bus_b.wb_stb_i = 0; bus_b.wb_we_i = 0;
    @(negedge clk);
    check("b_ack_once", 32'(bus_b.wb_ack_o), 32'd0);
    check("b_ctrl", 32'(ctrl_b), 32'd1);

    @(negedge clk);
    bus_b.wb_cyc_i = 1; bus_b.wb_stb_i = 1; bus_b.wb_we_i = 1;
    bus_b.wb_adr_i = 8'h24; bus_b.wb_dat_i = 32'h55;
    repeat (2) @(negedge clk);
    bus_b.wb_cyc_i = 0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen |= bus_b.wb_ack_o;
    end
    bus_b.wb_stb_i = 0; bus_b.wb_we_i = 0;
    check("b_abort_ack", 32'(seen), 32'd0);
    check("b_abort_reg", 32'(clkdiv_b), 32'd0);

    // Reset during the commit edge: no ack, no write.
    @(negedge clk);
    bus_a.wb_cyc_i = 1; bus_a.wb_stb_i = 1; bus_a.wb_we_i = 1;
    bus_a.wb_adr_i = 8'h24; bus_a.wb_dat_i = 32'h77; bus_a.wb_sel_i = 4'hF;
    rst = 1;
    @(negedge clk);
    check("rst_mid_ack", 32'(bus_a.wb_ack_o), 32'd0);
    check("rst_mid_reg", 32'(clkdiv_a), 32'd0);
    bus_a.wb_cyc_i = 0; bus_a.wb_stb_i = 0; bus_a.wb_we_i = 0;

    do_reset();
    resp = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 60; i++) begin
      a = addrs[$urandom_range(0, 22)];
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      busy = 1'($urandom_range(0, 1));
      cmd_busy = busy;
      access(1, 8'(a), d, s, 0);
      model_write(a, d, s, busy);
      check($sformatf("rnd_start_%0d", i), 32'(st_ack), 32'(a == 0 && !busy));
      cmd_busy = 0;
      access(0, 8'(a), 0, 4'hF, 0);
      check($sformatf("rnd_rd_%0d_%h", i, a), rd, model_read(a));
      check($sformatf("rnd_cint_%0d", i), 32'(cint_a), 32'(|(mreg['h34] & mreg['h38])));
    end
    check("rnd_arg", arg_a, mreg['h00]);
    check("rnd_cmd", 32'(command_a), mreg['h04]);
    check("rnd_ctrl", {ctrl_a, swrst_a}, {mreg['h1C][0], mreg['h28][0]});
    check("rnd_cto", 32'(cto_a), mreg['h20]);
    check("rnd_clkdiv", 32'(clkdiv_a), mreg['h24]);
    check("rnd_bsize", 32'(bsize_a), mreg['h44]);
    check("rnd_bcnt", 32'(bcnt_a), mreg['h48]);
    check("rnd_dto", 32'(dto_a), mreg['h4C]);
    check("rnd_dma", dma_a, mreg['h60]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
